// File: rtl/vec_fifo_pkg.sv
// ---------------------------------------------------------------------------
// vec_fifo_pkg
// Shared types and width helpers for the vector FIFO and its write/read
// scheduler. The helpers are used both for port sizing and for elaboration
// checks, so the FIFO and the scheduler agree on every derived width.
// ---------------------------------------------------------------------------
package vec_fifo_pkg;

    // Write-side FSM: IDLE arbitrates, BURST streams one whole vector.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wr_state_t;

    // Beats needed to move one vector at a given beat width.
    function automatic int beats_per_vec(input int vec_bytes, input int beat_bytes);
        return vec_bytes / beat_bytes;
    endfunction

    // Width of an index over n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // True when a vector splits into a whole number of beats.
    function automatic bit divides(input int vec_bytes, input int beat_bytes);
        return (beat_bytes > 0) && ((vec_bytes % beat_bytes) == 0);
    endfunction

endpackage

// File: rtl/vec_fifo_sched_if.sv
// ---------------------------------------------------------------------------
// vec_fifo_sched_if
// Bundles every non-clock signal of vec_fifo_sched.
//   producers : req_valid_in, req_data_in  -> scheduler; req_ready_out back
//   FIFO side : fifo_wr_en_out, fifo_wr_data_out, fifo_rd_en_out out;
//               fifo_rd_data_in in (head word, combinational)
//   consumer  : rd_valid_out, rd_data_out, rd_last_out out; rd_ready_in in
//   status    : alloc_out, full_out, empty_out
// Modports: master = surrounding logic, slave = the scheduler.
// ---------------------------------------------------------------------------
interface vec_fifo_sched_if #(
    parameter int VecElements   = 8,
    parameter int BytesPerWrite = 2,
    parameter int BytesPerRead  = 4,
    parameter int Depth         = 16,
    parameter int NumReq        = 2
);
    localparam int AW = vec_fifo_pkg::cnt_width(Depth);

    logic [NumReq-1:0]                     req_valid_in;
    logic [NumReq-1:0][BytesPerWrite-1:0][7:0] req_data_in;
    logic [NumReq-1:0]                     req_ready_out;
    logic                                  fifo_wr_en_out;
    logic [BytesPerWrite-1:0][7:0]         fifo_wr_data_out;
    logic                                  fifo_rd_en_out;
    logic [BytesPerRead-1:0][7:0]          fifo_rd_data_in;
    logic                                  rd_valid_out;
    logic                                  rd_ready_in;
    logic [BytesPerRead-1:0][7:0]          rd_data_out;
    logic                                  rd_last_out;
    logic [AW-1:0]                         alloc_out;
    logic                                  full_out;
    logic                                  empty_out;

    modport master (
        output req_valid_in, req_data_in, fifo_rd_data_in, rd_ready_in,
        input  req_ready_out, fifo_wr_en_out, fifo_wr_data_out, fifo_rd_en_out,
               rd_valid_out, rd_data_out, rd_last_out, alloc_out, full_out, empty_out
    );

    modport slave (
        input  req_valid_in, req_data_in, fifo_rd_data_in, rd_ready_in,
        output req_ready_out, fifo_wr_en_out, fifo_wr_data_out, fifo_rd_en_out,
               rd_valid_out, rd_data_out, rd_last_out, alloc_out, full_out, empty_out
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: grants the first asserted request
// at or after ptr, wrapping modulo NumReq.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   grant : one-hot winner (zero when no request)
//   any   : at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter
    import vec_fifo_pkg::*;
#(
    parameter  int NumReq = 2,
    localparam int PW     = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [NumReq-1:0] grant,
    output logic              any
);

    always_comb begin : pick
        int idx;
        // NOTE: combinational blocks use blocking assignments and give every
        // output a default first, so no path can leave a latch behind.
        idx   = 0;
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            idx = (int'(ptr) + i) % NumReq;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vec_fifo_sched.sv
// ---------------------------------------------------------------------------
// vec_fifo_sched
// Vector-granular scheduler in front of a vector FIFO. Shares the FIFO write
// port between NumReq producers, locking one producer for a whole vector,
// tracks allocated/committed vector slots and releases only committed
// vectors on the read side, flagging the last beat of each.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   bus (slave)      : producer, FIFO, consumer and status signals
// ---------------------------------------------------------------------------
module vec_fifo_sched
    import vec_fifo_pkg::*;
#(
    parameter int VecElements   = 8,
    parameter int BytesPerWrite = 2,
    parameter int BytesPerRead  = 4,
    parameter int Depth         = 16,
    parameter int NumReq        = 2
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    vec_fifo_sched_if.slave bus
);

    localparam int WPV = beats_per_vec(VecElements, BytesPerWrite);
    localparam int RPV = beats_per_vec(VecElements, BytesPerRead);
    localparam int AW  = cnt_width(Depth);
    localparam int PW  = idx_width(NumReq);
    localparam int WBW = idx_width(WPV);
    localparam int RBW = idx_width(RPV);

    localparam logic [AW-1:0]  DEPTH_C    = AW'(Depth);
    localparam logic [WBW-1:0] WBEAT_LAST = WBW'(WPV - 1);
    localparam logic [RBW-1:0] RBEAT_LAST = RBW'(RPV - 1);
    localparam logic [PW-1:0]  PTR_LAST   = PW'(NumReq - 1);

    generate
        if (!divides(VecElements, BytesPerWrite)) begin : g_bad_wr
            $error("BytesPerWrite must divide VecElements");
        end
        if (!divides(VecElements, BytesPerRead)) begin : g_bad_rd
            $error("BytesPerRead must divide VecElements");
        end
        if (NumReq < 1) begin : g_bad_req
            $error("NumReq must be at least 1");
        end
    endgenerate

    wr_state_t         state_q, state_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WBW-1:0]    wbeat_q, wbeat_d;
    logic [RBW-1:0]    rbeat_q, rbeat_d;
    logic [AW-1:0]     alloc_q, alloc_d;
    logic [AW-1:0]     committed_q, committed_d;

    logic [NumReq-1:0] arb_grant;
    logic              arb_any;
    logic [PW-1:0]     arb_idx;

    logic [NumReq-1:0] ready;
    logic              wr_en;
    logic              alloc_inc;
    logic              commit;
    logic              rd_valid;
    logic              pop;
    logic              last_pop;

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .req   (bus.req_valid_in),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .any   (arb_any)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (arb_grant[i]) begin
                arb_idx = PW'(i);
            end
        end
    end

    // Write FSM. The slot is reserved at grant time so a full FIFO can never
    // be handed a vector it cannot hold; ready depends on registered state only.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        wbeat_d   = wbeat_q;
        rr_ptr_d  = rr_ptr_q;
        alloc_inc = 1'b0;
        commit    = 1'b0;
        wr_en     = 1'b0;
        ready     = '0;
        case (state_q)
            IDLE: begin
                if (arb_any && (alloc_q < DEPTH_C)) begin
                    grant_d   = arb_idx;
                    alloc_inc = 1'b1;
                    wbeat_d   = '0;
                    state_d   = BURST;
                end
            end
            BURST: begin
                ready[grant_q] = 1'b1;
                if (bus.req_valid_in[grant_q]) begin
                    wr_en = 1'b1;
                    if (wbeat_q == WBEAT_LAST) begin
                        commit   = 1'b1;
                        rr_ptr_d = (grant_q == PTR_LAST) ? '0 : grant_q + PW'(1);
                        wbeat_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        wbeat_d = wbeat_q + WBW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read side: only committed vectors are visible to the consumer.
    always_comb begin
        rd_valid = (committed_q != '0);
        pop      = rd_valid && bus.rd_ready_in;
        last_pop = pop && (rbeat_q == RBEAT_LAST);
        rbeat_d  = rbeat_q;
        if (pop) begin
            rbeat_d = (rbeat_q == RBEAT_LAST) ? '0 : rbeat_q + RBW'(1);
        end
    end

    // Slot accounting: simultaneous increment and decrement cancel.
    always_comb begin
        alloc_d     = alloc_q;
        committed_d = committed_q;
        if (alloc_inc && !last_pop) begin
            alloc_d = alloc_q + AW'(1);
        end else if (!alloc_inc && last_pop) begin
            alloc_d = alloc_q - AW'(1);
        end
        if (commit && !last_pop) begin
            committed_d = committed_q + AW'(1);
        end else if (!commit && last_pop) begin
            committed_d = committed_q - AW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments and are all cleared
    // by the asynchronous reset; the FIFO resets alongside, so nothing partial
    // survives a mid-vector reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            wbeat_q     <= '0;
            rbeat_q     <= '0;
            alloc_q     <= '0;
            committed_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            wbeat_q     <= wbeat_d;
            rbeat_q     <= rbeat_d;
            alloc_q     <= alloc_d;
            committed_q <= committed_d;
        end
    end

    assign bus.req_ready_out    = ready;
    assign bus.fifo_wr_en_out   = wr_en;
    assign bus.fifo_wr_data_out = wr_en ? bus.req_data_in[grant_q] : '0;
    assign bus.fifo_rd_en_out   = pop;
    assign bus.rd_valid_out     = rd_valid;
    assign bus.rd_data_out      = bus.fifo_rd_data_in;
    assign bus.rd_last_out      = (rbeat_q == RBEAT_LAST);
    assign bus.alloc_out        = alloc_q;
    assign bus.full_out         = (alloc_q == DEPTH_C);
    assign bus.empty_out        = (alloc_q == '0);

endmodule

// File: tb/tb_vec_fifo_sched.sv
// ---------------------------------------------------------------------------
// tb_vec_fifo_sched
// Directed bench for vec_fifo_sched. Instance a uses default parameters,
// instance b uses Depth = 2 for the full/back-pressure scenario. Inputs are
// driven 1 time unit after the rising edge and outputs sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_vec_fifo_sched;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] t1_beats [4] = '{16'h0000, 16'hFF01, 16'hFE02, 16'hFD03};

    vec_fifo_sched_if #(.Depth(16)) bus_a ();
    vec_fifo_sched_if #(.Depth(2))  bus_b ();

    vec_fifo_sched #(
        .VecElements(8), .BytesPerWrite(2), .BytesPerRead(4), .Depth(16), .NumReq(2)
    ) u_dut_a (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus_a.slave)
    );

    vec_fifo_sched #(
        .VecElements(8), .BytesPerWrite(2), .BytesPerRead(4), .Depth(2), .NumReq(2)
    ) u_dut_b (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_a.req_valid_in    = '0;
        bus_a.req_data_in     = '0;
        bus_a.fifo_rd_data_in = '0;
        bus_a.rd_ready_in     = 1'b0;
        bus_b.req_valid_in    = '0;
        bus_b.req_data_in     = '0;
        bus_b.fifo_rd_data_in = '0;
        bus_b.rd_ready_in     = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        #2;
        apply_reset();

        // Reset state
        check("rst ready", bus_a.req_ready_out, 0);
        check("rst wr_en", bus_a.fifo_wr_en_out, 0);
        check("rst rd_valid", bus_a.rd_valid_out, 0);
        check("rst alloc", bus_a.alloc_out, 0);
        check("rst empty", bus_a.empty_out, 1);
        check("rst full", bus_a.full_out, 0);

        // T1: single vector from producer 0, then two read beats
        bus_a.req_valid_in   = 2'b01;
        bus_a.req_data_in[0] = t1_beats[0];
        #1;
        check("t1 idle ready", bus_a.req_ready_out, 0);
        step();
        for (int b = 0; b < 4; b++) begin
            bus_a.req_data_in[0] = t1_beats[b];
            #1;
            check("t1 ready", bus_a.req_ready_out, 2'b01);
            check("t1 wr_en", bus_a.fifo_wr_en_out, 1);
            check("t1 wr_data", bus_a.fifo_wr_data_out, t1_beats[b]);
            check("t1 rd_valid early", bus_a.rd_valid_out, 0);
            step();
        end
        bus_a.req_valid_in = 2'b00;
        #1;
        check("t1 committed rd_valid", bus_a.rd_valid_out, 1);
        check("t1 alloc", bus_a.alloc_out, 1);
        check("t1 wr_en idle", bus_a.fifo_wr_en_out, 0);
        bus_a.rd_ready_in     = 1'b1;
        bus_a.fifo_rd_data_in = 32'h1122_3344;
        #1;
        check("t1 rd_en 0", bus_a.fifo_rd_en_out, 1);
        check("t1 rd_last 0", bus_a.rd_last_out, 0);
        check("t1 rd_data", bus_a.rd_data_out, 32'h1122_3344);
        step();
        bus_a.fifo_rd_data_in = 32'h5566_7788;
        #1;
        check("t1 rd_en 1", bus_a.fifo_rd_en_out, 1);
        check("t1 rd_last 1", bus_a.rd_last_out, 1);
        step();
        bus_a.rd_ready_in = 1'b0;
        #1;
        check("t1 drained rd_valid", bus_a.rd_valid_out, 0);
        check("t1 drained alloc", bus_a.alloc_out, 0);
        check("t1 drained empty", bus_a.empty_out, 1);

        // T2: both producers continuously valid, consumer stalled
        apply_reset();
        bus_a.req_data_in[0] = 16'hA0A0;
        bus_a.req_data_in[1] = 16'hB1B1;
        bus_a.req_valid_in   = 2'b11;
        for (int v = 0; v < 4; v++) begin
            #1;
            check("t2 bubble ready", bus_a.req_ready_out, 0);
            step();
            for (int b = 0; b < 4; b++) begin
                #1;
                check("t2 ready", bus_a.req_ready_out, (v % 2 == 0) ? 2'b01 : 2'b10);
                check("t2 wr_en", bus_a.fifo_wr_en_out, 1);
                if (b == 0) begin
                    check("t2 wr_data", bus_a.fifo_wr_data_out, (v % 2 == 0) ? 16'hA0A0 : 16'hB1B1);
                end
                step();
            end
        end
        #1;
        check("t2 alloc", bus_a.alloc_out, 4);
        check("t2 rd_valid", bus_a.rd_valid_out, 1);

        // T4: granted producer 0 drops valid for 3 cycles mid-vector
        step();
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                bus_a.req_valid_in = 2'b10;
                for (int g = 0; g < 3; g++) begin
                    #1;
                    check("t4 gap ready", bus_a.req_ready_out, 2'b01);
                    check("t4 gap wr_en", bus_a.fifo_wr_en_out, 0);
                    step();
                end
                bus_a.req_valid_in = 2'b11;
            end
            bus_a.req_data_in[0] = 16'hC000 + 16'(b);
            #1;
            check("t4 ready", bus_a.req_ready_out, 2'b01);
            check("t4 wr_en", bus_a.fifo_wr_en_out, 1);
            check("t4 wr_data", bus_a.fifo_wr_data_out, 16'hC000 + 16'(b));
            step();
        end
        bus_a.req_valid_in = 2'b00;
        #1;
        check("t4 alloc", bus_a.alloc_out, 5);
        check("t4 idle ready", bus_a.req_ready_out, 0);

        // T5: commit coincides with last read pop; then grant coincides with one
        apply_reset();
        bus_a.req_valid_in   = 2'b01;
        bus_a.req_data_in[0] = 16'hD0D0;
        repeat (5) step();
        #1;
        check("t5 first commit", bus_a.rd_valid_out, 1);
        check("t5 alloc 1", bus_a.alloc_out, 1);
        repeat (3) step();
        bus_a.rd_ready_in = 1'b1;
        #1;
        check("t5 beat2 rd_last", bus_a.rd_last_out, 0);
        step();
        #1;
        check("t5 beat3 rd_last", bus_a.rd_last_out, 1);
        check("t5 beat3 wr_en", bus_a.fifo_wr_en_out, 1);
        check("t5 beat3 alloc", bus_a.alloc_out, 2);
        step();
        bus_a.req_valid_in = 2'b00;
        #1;
        check("t5 committed held", bus_a.rd_valid_out, 1);
        check("t5 alloc after pop", bus_a.alloc_out, 1);
        step();
        bus_a.req_valid_in = 2'b01;
        #1;
        check("t5 grant cycle rd_last", bus_a.rd_last_out, 1);
        check("t5 grant cycle ready", bus_a.req_ready_out, 0);
        step();
        bus_a.rd_ready_in = 1'b0;
        #1;
        check("t5 grant+pop alloc", bus_a.alloc_out, 1);
        check("t5 rd_valid drained", bus_a.rd_valid_out, 0);
        check("t5 burst ready", bus_a.req_ready_out, 2'b01);

        // T6: reset asserted with wbeat = 2
        repeat (2) step();
        bus_a.req_valid_in = 2'b11;
        #1;
        check("t6 pre ready", bus_a.req_ready_out, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst ready", bus_a.req_ready_out, 0);
        check("t6 rst wr_en", bus_a.fifo_wr_en_out, 0);
        check("t6 rst wr_data", bus_a.fifo_wr_data_out, 0);
        check("t6 rst rd_valid", bus_a.rd_valid_out, 0);
        check("t6 rst rd_en", bus_a.fifo_rd_en_out, 0);
        check("t6 rst rd_last", bus_a.rd_last_out, 0);
        check("t6 rst alloc", bus_a.alloc_out, 0);
        check("t6 rst full", bus_a.full_out, 0);
        check("t6 rst empty", bus_a.empty_out, 1);
        rst_n = 1'b1;
        #1;
        check("t6 idle ready", bus_a.req_ready_out, 0);
        step();
        check("t6 rr_ptr zero grant", bus_a.req_ready_out, 2'b01);

        // T3: Depth = 2 with consumer stalled
        apply_reset();
        bus_b.req_valid_in   = 2'b01;
        bus_b.req_data_in[0] = 16'h1234;
        step();
        #1;
        check("t3 wr_en", bus_b.fifo_wr_en_out, 1);
        repeat (9) step();
        #1;
        check("t3 full", bus_b.full_out, 1);
        check("t3 alloc", bus_b.alloc_out, 2);
        check("t3 rd_valid", bus_b.rd_valid_out, 1);
        for (int c = 0; c < 3; c++) begin
            check("t3 held ready", bus_b.req_ready_out, 0);
            step();
        end
        bus_b.rd_ready_in = 1'b1;
        #1;
        check("t3 pop0 rd_last", bus_b.rd_last_out, 0);
        step();
        #1;
        check("t3 pop1 rd_last", bus_b.rd_last_out, 1);
        check("t3 pop1 ready", bus_b.req_ready_out, 0);
        step();
        bus_b.rd_ready_in = 1'b0;
        #1;
        check("t3 freed alloc", bus_b.alloc_out, 1);
        check("t3 freed full", bus_b.full_out, 0);
        check("t3 freed ready", bus_b.req_ready_out, 0);
        step();
        check("t3 regrant ready", bus_b.req_ready_out, 2'b01);
        check("t3 regrant alloc", bus_b.alloc_out, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
